// File: rtl/lc3_pkg.sv
// Shared LC-3 control encodings: FSM states, opcodes, mux selects and the control word.
// Define LC3_PAUSE_EN to add the PAUSE1/PAUSE2 states.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED = 5'd0,
    S_FETCH1 = 5'd1,
    S_FETCH2 = 5'd2,
    S_FETCH3 = 5'd3,
    S_DECODE = 5'd4,
    S_ADD    = 5'd5,
    S_AND    = 5'd6,
    S_NOT    = 5'd7,
    S_BR1    = 5'd8,
    S_BR2    = 5'd9,
    S_JMP    = 5'd10,
    S_JSR1   = 5'd11,
    S_JSR2   = 5'd12,
    S_LDR1   = 5'd13,
    S_LDR2   = 5'd14,
    S_LDR3   = 5'd15,
    S_STR1   = 5'd16,
    S_STR2   = 5'd17,
    S_STR3   = 5'd18
`ifdef LC3_PAUSE_EN
    ,
    S_PAUSE1 = 5'd19,
    S_PAUSE2 = 5'd20
`endif
  } state_e;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_BUS   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] PCMUX_INC   = 2'b10;

  localparam logic [1:0] ADDR2_SEXT11 = 2'b00;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO   = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic       addr1mux;
    logic [1:0] aluk;
    logic       drmux, sr1mux, sr2mux, mio_en;
    logic       mem_oe_n, mem_we_n;
  } ctrl_t;

  // Memory strobes are active-low, so the idle word has them high.
  localparam ctrl_t CTRL_IDLE = '{mem_oe_n: 1'b1, mem_we_n: 1'b1, default: '0};

  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

// File: rtl/lc3_control_if.sv
// Control/status bundle between lc3_control (master) and the LC-3 datapath (slave).
interface lc3_control_if;
  logic       Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;

  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX;
  logic       ADDR1MUX;
  logic [1:0] ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, MIO_EN;
  logic       Mem_OE, Mem_WE;
  logic [4:0] State;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, ADDR2MUX, ADDR1MUX, ALUK,
           DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE, State
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, ADDR2MUX, ADDR1MUX, ALUK,
           DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE, State
  );
endinterface

// File: rtl/lc3_wait_counter.sv
// Loadable down-counter with zero flag; times memory read/write strobes.
module lc3_wait_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          count_q <= '0;
    else if (load_i)                  count_q <= load_val_i;
    else if (dec_i && count_q != '0)  count_q <= count_q - 1'b1;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lc3_control.sv
// LC-3 control unit: Moore FSM driving every datapath load, gate, mux and memory strobe.
// Define LC3_PAUSE_EN to decode opcode 1101 as a Continue-handshaked PAUSE.
module lc3_control
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic          Clk,
  input  logic          Reset_ah,
  lc3_control_if.master bus
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   wait_zero, wait_load, wait_dec;

  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) state_q <= S_HALTED;
    else          state_q <= state_d;
  end

  // Counter loads on entry to a memory state so the first cycle already sees MEM_WAIT-1.
  assign wait_load = is_wait_state(state_d) && (state_d != state_q);
  assign wait_dec  = is_wait_state(state_q);

  lc3_wait_counter #(.WIDTH(3)) u_wait (
    .clk        (Clk),
    .rst        (Reset_ah),
    .load_i     (wait_load),
    .load_val_i (WAIT_INIT),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    case (state_q)
      S_HALTED: if (bus.Run) state_d = S_FETCH1;
      S_FETCH1: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_mar  = 1'b1;
        ctrl.pcmux   = PCMUX_INC;
        ctrl.ld_pc   = 1'b1;
        state_d      = S_FETCH2;
      end
      S_FETCH2, S_LDR2: begin
        ctrl.mem_oe_n = 1'b0;
        ctrl.mio_en   = 1'b1;
        if (wait_zero) begin
          ctrl.ld_mdr = 1'b1;
          state_d     = (state_q == S_FETCH2) ? S_FETCH3 : S_LDR3;
        end
      end
      S_FETCH3: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_ir    = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        ctrl.ld_ben = 1'b1;
        case (bus.Opcode)
          OP_ADD:   state_d = S_ADD;
          OP_AND:   state_d = S_AND;
          OP_NOT:   state_d = S_NOT;
          OP_BR:    state_d = S_BR1;
          OP_JMP:   state_d = S_JMP;
          OP_JSR:   state_d = S_JSR1;
          OP_LDR:   state_d = S_LDR1;
          OP_STR:   state_d = S_STR1;
`ifdef LC3_PAUSE_EN
          OP_PAUSE: state_d = S_PAUSE1;
`endif
          default:  state_d = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        ctrl.sr1mux   = 1'b1;
        ctrl.sr2mux   = (state_q == S_NOT) ? 1'b0 : bus.IR_5;
        ctrl.aluk     = (state_q == S_ADD) ? ALUK_ADD :
                        (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        state_d       = S_FETCH1;
      end
      S_BR1: state_d = bus.BEN ? S_BR2 : S_FETCH1;
      S_BR2: begin
        ctrl.addr1mux = 1'b1;
        ctrl.addr2mux = ADDR2_SEXT9;
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.ld_pc    = 1'b1;
        state_d       = S_FETCH1;
      end
      S_JMP: begin
        ctrl.sr1mux   = 1'b1;
        ctrl.addr2mux = ADDR2_ZERO;
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.ld_pc    = 1'b1;
        state_d       = S_FETCH1;
      end
      S_JSR1: begin
        ctrl.gate_pc = 1'b1;
        ctrl.drmux   = 1'b1;
        ctrl.ld_reg  = 1'b1;
        state_d      = S_JSR2;
      end
      S_JSR2: begin
        // JSR adds SEXT11 to PC; JSRR passes BaseR through the adder with a zero offset.
        ctrl.addr1mux = bus.IR_11;
        ctrl.sr1mux   = ~bus.IR_11;
        ctrl.addr2mux = bus.IR_11 ? ADDR2_SEXT11 : ADDR2_ZERO;
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.ld_pc    = 1'b1;
        state_d       = S_FETCH1;
      end
      S_LDR1, S_STR1: begin
        ctrl.sr1mux      = 1'b1;
        ctrl.addr2mux    = ADDR2_SEXT6;
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
        state_d          = (state_q == S_LDR1) ? S_LDR2 : S_STR2;
      end
      S_LDR3: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        state_d       = S_FETCH1;
      end
      S_STR2: begin
        ctrl.aluk     = ALUK_PASS;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_mdr   = 1'b1;
        state_d       = S_STR3;
      end
      S_STR3: begin
        ctrl.mem_we_n = 1'b0;
        if (wait_zero) state_d = S_FETCH1;
      end
`ifdef LC3_PAUSE_EN
      // Two-phase handshake: a Continue still held high cannot release a later PAUSE.
      S_PAUSE1: if (bus.Continue)  state_d = S_PAUSE2;
      S_PAUSE2: if (!bus.Continue) state_d = S_FETCH1;
`endif
      default: state_d = S_HALTED;
    endcase
  end

`ifndef LC3_PAUSE_EN
  logic unused_continue;
  assign unused_continue = bus.Continue;
`endif

  assign bus.LD_MAR     = ctrl.ld_mar;
  assign bus.LD_MDR     = ctrl.ld_mdr;
  assign bus.LD_IR      = ctrl.ld_ir;
  assign bus.LD_BEN     = ctrl.ld_ben;
  assign bus.LD_CC      = ctrl.ld_cc;
  assign bus.LD_REG     = ctrl.ld_reg;
  assign bus.LD_PC      = ctrl.ld_pc;
  assign bus.GatePC     = ctrl.gate_pc;
  assign bus.GateMDR    = ctrl.gate_mdr;
  assign bus.GateALU    = ctrl.gate_alu;
  assign bus.GateMARMUX = ctrl.gate_marmux;
  assign bus.PCMUX      = ctrl.pcmux;
  assign bus.ADDR2MUX   = ctrl.addr2mux;
  assign bus.ADDR1MUX   = ctrl.addr1mux;
  assign bus.ALUK       = ctrl.aluk;
  assign bus.DRMUX      = ctrl.drmux;
  assign bus.SR1MUX     = ctrl.sr1mux;
  assign bus.SR2MUX     = ctrl.sr2mux;
  assign bus.MIO_EN     = ctrl.mio_en;
  assign bus.Mem_OE     = ctrl.mem_oe_n;
  assign bus.Mem_WE     = ctrl.mem_we_n;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_lc3_control.sv
// Directed, table-driven bench for lc3_control (MEM_WAIT=2 main instance, MEM_WAIT=1 corner instance).
module tb_lc3_control;
  import lc3_pkg::*;

  logic Clk = 1'b0;
  logic Reset_ah;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 Clk = ~Clk;

  lc3_control_if bus ();
  lc3_control_if bus1 ();

  lc3_control #(.MEM_WAIT(2)) dut  (.Clk(Clk), .Reset_ah(Reset_ah), .bus(bus));
  lc3_control #(.MEM_WAIT(1)) dut1 (.Clk(Clk), .Reset_ah(Reset_ah), .bus(bus1));

  // One bit per control line; the two memory strobes are recorded as "driven low".
  localparam logic [17:0] F_LDMAR  = 18'b1 << 0;
  localparam logic [17:0] F_LDMDR  = 18'b1 << 1;
  localparam logic [17:0] F_LDIR   = 18'b1 << 2;
  localparam logic [17:0] F_LDBEN  = 18'b1 << 3;
  localparam logic [17:0] F_LDCC   = 18'b1 << 4;
  localparam logic [17:0] F_LDREG  = 18'b1 << 5;
  localparam logic [17:0] F_LDPC   = 18'b1 << 6;
  localparam logic [17:0] F_GPC    = 18'b1 << 7;
  localparam logic [17:0] F_GMDR   = 18'b1 << 8;
  localparam logic [17:0] F_GALU   = 18'b1 << 9;
  localparam logic [17:0] F_GMMUX  = 18'b1 << 10;
  localparam logic [17:0] F_DRMUX  = 18'b1 << 11;
  localparam logic [17:0] F_SR1    = 18'b1 << 12;
  localparam logic [17:0] F_SR2    = 18'b1 << 13;
  localparam logic [17:0] F_ADDR1  = 18'b1 << 14;
  localparam logic [17:0] F_MIO    = 18'b1 << 15;
  localparam logic [17:0] F_OEL    = 18'b1 << 16;
  localparam logic [17:0] F_WEL    = 18'b1 << 17;

  typedef struct {
    string      name;
    logic       run;
    logic [3:0] op;
    logic       ir5, ir11, ben;
    state_e     st;
    logic [17:0] fl;
    logic [1:0] pm, a2, ak;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] act_flags();
    return {~bus.Mem_WE, ~bus.Mem_OE, bus.MIO_EN, bus.ADDR1MUX, bus.SR2MUX, bus.SR1MUX,
            bus.DRMUX, bus.GateMARMUX, bus.GateALU, bus.GateMDR, bus.GatePC, bus.LD_PC,
            bus.LD_REG, bus.LD_CC, bus.LD_BEN, bus.LD_IR, bus.LD_MDR, bus.LD_MAR};
  endfunction

  function automatic logic [31:0] act_vec();
    return {3'b0, bus.State, act_flags(), bus.PCMUX, bus.ADDR2MUX, bus.ALUK};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [3:0] op, input logic ir5, ir11, ben,
                      input state_e st, input logic [17:0] fl,
                      input logic [1:0] pm, a2, ak, input logic run = 1'b1);
    vec_t v;
    v.name = nm; v.run = run; v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben;
    v.st = st; v.fl = fl; v.pm = pm; v.a2 = a2; v.ak = ak;
    vecs.push_back(v);
  endtask

  // FETCH1, two FETCH2 cycles (MEM_WAIT=2, LD_MDR on the second), FETCH3, DECODE.
  task automatic push_fetch(input string nm, input logic [3:0] op, input logic ir5, ir11, ben);
    push({nm, "_f1"},  op, ir5, ir11, ben, S_FETCH1, F_LDMAR | F_GPC | F_LDPC, 2'b10, 2'b00, 2'b00);
    push({nm, "_f2a"}, op, ir5, ir11, ben, S_FETCH2, F_MIO | F_OEL,            2'b00, 2'b00, 2'b00);
    push({nm, "_f2b"}, op, ir5, ir11, ben, S_FETCH2, F_MIO | F_OEL | F_LDMDR,  2'b00, 2'b00, 2'b00);
    push({nm, "_f3"},  op, ir5, ir11, ben, S_FETCH3, F_GMDR | F_LDIR,          2'b00, 2'b00, 2'b00);
    push({nm, "_dec"}, op, ir5, ir11, ben, S_DECODE, F_LDBEN,                  2'b00, 2'b00, 2'b00);
  endtask

  task automatic wait_state(input state_e s, input int budget, input string nm);
    int n = 0;
    while (bus.State !== s && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check(nm, {27'b0, bus.State}, {27'b0, s});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_ah = 1'b1;
    bus.Run = 0; bus.Continue = 0; bus.Opcode = 4'h0; bus.IR_5 = 0; bus.IR_11 = 0; bus.BEN = 0;
    bus1.Run = 0; bus1.Continue = 0; bus1.Opcode = OP_STR; bus1.IR_5 = 0; bus1.IR_11 = 0; bus1.BEN = 0;

    push("idle", 4'h0, 0, 0, 0, S_HALTED, '0, 2'b00, 2'b00, 2'b00, 1'b0);
    push("run",  4'h0, 0, 0, 0, S_HALTED, '0, 2'b00, 2'b00, 2'b00, 1'b1);
    push_fetch("add", 4'b0001, 1, 0, 0);
    push("add_ex", 4'b0001, 1, 0, 0, S_ADD, F_SR1 | F_SR2 | F_GALU | F_LDREG | F_LDCC, 2'b00, 2'b00, 2'b00);
    push_fetch("and", 4'b0101, 0, 0, 0);
    push("and_ex", 4'b0101, 0, 0, 0, S_AND, F_SR1 | F_GALU | F_LDREG | F_LDCC, 2'b00, 2'b00, 2'b01);
    push_fetch("not", 4'b1001, 0, 0, 0);
    push("not_ex", 4'b1001, 0, 0, 0, S_NOT, F_SR1 | F_GALU | F_LDREG | F_LDCC, 2'b00, 2'b00, 2'b10);
    push_fetch("br0", 4'b0000, 0, 0, 0);
    push("br0_br1", 4'b0000, 0, 0, 0, S_BR1, '0, 2'b00, 2'b00, 2'b00);
    push_fetch("br1", 4'b0000, 0, 0, 1);
    push("br1_br1", 4'b0000, 0, 0, 1, S_BR1, '0, 2'b00, 2'b00, 2'b00);
    push("br1_br2", 4'b0000, 0, 0, 1, S_BR2, F_ADDR1 | F_LDPC, 2'b01, 2'b01, 2'b00);
    push_fetch("jmp", 4'b1100, 0, 0, 0);
    push("jmp_ex", 4'b1100, 0, 0, 0, S_JMP, F_SR1 | F_LDPC, 2'b01, 2'b11, 2'b00);
    push_fetch("jsr", 4'b0100, 0, 1, 0);
    push("jsr_1", 4'b0100, 0, 1, 0, S_JSR1, F_GPC | F_DRMUX | F_LDREG, 2'b00, 2'b00, 2'b00);
    push("jsr_2", 4'b0100, 0, 1, 0, S_JSR2, F_ADDR1 | F_LDPC, 2'b01, 2'b00, 2'b00);
    push_fetch("jsrr", 4'b0100, 0, 0, 0);
    push("jsrr_1", 4'b0100, 0, 0, 0, S_JSR1, F_GPC | F_DRMUX | F_LDREG, 2'b00, 2'b00, 2'b00);
    push("jsrr_2", 4'b0100, 0, 0, 0, S_JSR2, F_SR1 | F_LDPC, 2'b01, 2'b11, 2'b00);
    push_fetch("ldr", 4'b0110, 0, 0, 0);
    push("ldr_1",  4'b0110, 0, 0, 0, S_LDR1, F_SR1 | F_GMMUX | F_LDMAR, 2'b00, 2'b10, 2'b00);
    push("ldr_2a", 4'b0110, 0, 0, 0, S_LDR2, F_MIO | F_OEL, 2'b00, 2'b00, 2'b00);
    push("ldr_2b", 4'b0110, 0, 0, 0, S_LDR2, F_MIO | F_OEL | F_LDMDR, 2'b00, 2'b00, 2'b00);
    push("ldr_3",  4'b0110, 0, 0, 0, S_LDR3, F_GMDR | F_LDREG | F_LDCC, 2'b00, 2'b00, 2'b00);
    push_fetch("str", 4'b0111, 0, 0, 0);
    push("str_1",  4'b0111, 0, 0, 0, S_STR1, F_SR1 | F_GMMUX | F_LDMAR, 2'b00, 2'b10, 2'b00);
    push("str_2",  4'b0111, 0, 0, 0, S_STR2, F_GALU | F_LDMDR, 2'b00, 2'b00, 2'b11);
    push("str_3a", 4'b0111, 0, 0, 0, S_STR3, F_WEL, 2'b00, 2'b00, 2'b00);
    push("str_3b", 4'b0111, 0, 0, 0, S_STR3, F_WEL, 2'b00, 2'b00, 2'b00);
    push_fetch("nop", 4'b1111, 0, 0, 0);
    push("end_f1", 4'b1111, 0, 0, 0, S_FETCH1, F_LDMAR | F_GPC | F_LDPC, 2'b10, 2'b00, 2'b00);

    // Reset state before any clock edge.
    #2;
    check("reset_async", act_vec(), {3'b0, S_HALTED, 18'b0, 6'b0});

    @(negedge Clk);
    Reset_ah = 1'b0;
    foreach (vecs[i]) begin
      bus.Run = vecs[i].run; bus.Opcode = vecs[i].op;
      bus.IR_5 = vecs[i].ir5; bus.IR_11 = vecs[i].ir11; bus.BEN = vecs[i].ben;
      #1;
      check(vecs[i].name, act_vec(),
            {3'b0, vecs[i].st, vecs[i].fl, vecs[i].pm, vecs[i].a2, vecs[i].ak});
      check({vecs[i].name, "_gates"}, 32'($countones({bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX}) <= 1), 32'd1);
      check({vecs[i].name, "_strb"}, {31'b0, bus.Mem_OE | bus.Mem_WE}, 32'd1);
      @(negedge Clk);
    end

    // Opcode 1101 with Continue asserted.
    bus.Opcode = OP_PAUSE;
    bus.Continue = 1'b1;
    wait_state(S_DECODE, 10, "pause_dec");
    @(negedge Clk);
`ifdef LC3_PAUSE_EN
    check("pause1_enter", {27'b0, bus.State}, {27'b0, S_PAUSE1});
    @(negedge Clk);
    check("pause2_held", {27'b0, bus.State}, {27'b0, S_PAUSE2});
    repeat (2) @(negedge Clk);
    check("pause2_wait", {27'b0, bus.State}, {27'b0, S_PAUSE2});
    bus.Continue = 1'b0;
    @(negedge Clk);
    check("pause_exit", {27'b0, bus.State}, {27'b0, S_FETCH1});
    wait_state(S_DECODE, 10, "pause_dec2");
    repeat (3) @(negedge Clk);
    check("pause1_wait", {27'b0, bus.State}, {27'b0, S_PAUSE1});
    bus.Continue = 1'b1;
    @(negedge Clk);
    check("pause2_enter", {27'b0, bus.State}, {27'b0, S_PAUSE2});
    bus.Continue = 1'b0;
    @(negedge Clk);
    check("pause_exit2", {27'b0, bus.State}, {27'b0, S_FETCH1});
`else
    check("op1101_nop", {27'b0, bus.State}, {27'b0, S_FETCH1});
`endif

    // Reset asserted between edges in the middle of an LDR memory read.
    bus.Opcode = OP_LDR;
    wait_state(S_LDR2, 20, "ldr2_reach");
    #1 Reset_ah = 1'b1;
    #1 check("rst_mid_ldr2", act_vec(), {3'b0, S_HALTED, 18'b0, 6'b0});
    @(posedge Clk);
    #1 check("rst_held", act_vec(), {3'b0, S_HALTED, 18'b0, 6'b0});
    bus.Run = 1'b0;
    @(negedge Clk);
    Reset_ah = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("post_rst_idle", act_vec(), {3'b0, S_HALTED, 18'b0, 6'b0});
    end
    bus.Run = 1'b1;
    @(negedge Clk);
    check("restart_f1", {27'b0, bus.State}, {27'b0, S_FETCH1});
    bus.Run = 1'b0;

    // MEM_WAIT=1: single-cycle read in FETCH2 and single-cycle write in STR3.
    bus1.Run = 1'b1;
    @(negedge Clk);
    check("mw1_f1", {27'b0, bus1.State}, {27'b0, S_FETCH1});
    @(negedge Clk);
    check("mw1_f2", {24'b0, bus1.State, bus1.LD_MDR, bus1.Mem_OE, bus1.MIO_EN},
          {24'b0, S_FETCH2, 1'b1, 1'b0, 1'b1});
    @(negedge Clk);
    check("mw1_f3", {27'b0, bus1.State}, {27'b0, S_FETCH3});
    repeat (4) @(negedge Clk);
    check("mw1_str3", {25'b0, bus1.State, bus1.Mem_WE, bus1.Mem_OE},
          {25'b0, S_STR3, 1'b0, 1'b1});
    @(negedge Clk);
    check("mw1_str_done", {26'b0, bus1.State, bus1.Mem_WE}, {26'b0, S_FETCH1, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
